// File: rtl/bus_master_if.sv
// Per-core bus master: holds one load/store from the core pipeline, requests the
// systembus, waits for grant (and read latency), then pulses cpu_done.
module bus_master_if #(
    parameter int WIDTH       = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic [WIDTH-1:0] cpu_readdata,
    output logic             cpu_stall,
    output logic             cpu_done,
    output logic             request,
    input  logic             grant,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    output logic             memwrite,
    input  logic [WIDTH-1:0] memdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

    state_t           state_q, state_d;
    logic             op_write_q, op_write_d;
    logic [WIDTH-1:0] adr_q, adr_d;
    logic [WIDTH-1:0] writedata_q, writedata_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             request_q, request_d;
    logic             done_q, done_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            adr_q       <= '0;
            writedata_q <= '0;
            readdata_q  <= '0;
            cnt_q       <= 4'd0;
            request_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            adr_q       <= adr_d;
            writedata_q <= writedata_d;
            readdata_q  <= readdata_d;
            cnt_q       <= cnt_d;
            request_q   <= request_d;
            done_q      <= done_d;
        end
    end

    // Next-state, access latching, latency counting and read capture.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        adr_d       = adr_q;
        writedata_d = writedata_q;
        readdata_d  = readdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_memread || cpu_memwrite) begin
                    adr_d       = cpu_adr;
                    writedata_d = cpu_writedata;
                    op_write_d  = cpu_memwrite;
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (grant) begin
                    if (op_write_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                // Losing grant here restarts the whole latency on the next win.
                if (grant) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        readdata_d = memdata;
                        state_d    = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        request_d = (state_d == REQ) || (state_d == WAIT);
        done_d    = (state_d == DONE);
    end

    // Combinational outputs: stall and the single-cycle write strobe.
    always_comb begin
        cpu_stall = 1'b0;
        memwrite  = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_stall = cpu_memread | cpu_memwrite;
            end
            REQ: begin
                cpu_stall = 1'b1;
                memwrite  = grant & op_write_q;
            end
            WAIT: begin
                cpu_stall = 1'b1;
            end
            DONE: begin
                cpu_stall = 1'b0;
            end
            default: begin
                cpu_stall = 1'b0;
                memwrite  = 1'b0;
            end
        endcase
    end

    assign request      = request_q;
    assign cpu_done     = done_q;
    assign cpu_readdata = readdata_q;
    assign adr          = adr_q;
    assign writedata    = writedata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench: two bus masters (latency 1 and 3) sharing one memdata net,
// with a small memory model for the two-core arbitration scenario.
module tb_bus_master_if;

    logic       clk = 1'b0;
    logic       reset;
    logic       c0_rd, c0_wr, c1_rd, c1_wr;
    logic [7:0] c0_cadr, c0_cwd, c1_cadr, c1_cwd;
    logic [7:0] c0_rdata, c1_rdata;
    logic       c0_stall, c1_stall, c0_done, c1_done, c0_req, c1_req;
    logic       g0, g1;
    logic [7:0] c0_adr, c1_adr, c0_wd, c1_wd;
    logic       c0_mw, c1_mw;
    logic [7:0] memdata, md_force, model_rd;
    logic       use_model;
    logic [7:0] mem [256];
    logic [7:0] exp_rd0, exp_rd1;

    typedef struct {
        int         cyc;
        logic [7:0] rd;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bus_master_if #(.WIDTH(8), .MEM_LATENCY(1)) u_c0 (
        .clk(clk), .reset(reset),
        .cpu_memread(c0_rd), .cpu_memwrite(c0_wr),
        .cpu_adr(c0_cadr), .cpu_writedata(c0_cwd),
        .cpu_readdata(c0_rdata), .cpu_stall(c0_stall), .cpu_done(c0_done),
        .request(c0_req), .grant(g0),
        .adr(c0_adr), .writedata(c0_wd), .memwrite(c0_mw), .memdata(memdata)
    );

    bus_master_if #(.WIDTH(8), .MEM_LATENCY(3)) u_c1 (
        .clk(clk), .reset(reset),
        .cpu_memread(c1_rd), .cpu_memwrite(c1_wr),
        .cpu_adr(c1_cadr), .cpu_writedata(c1_cwd),
        .cpu_readdata(c1_rdata), .cpu_stall(c1_stall), .cpu_done(c1_done),
        .request(c1_req), .grant(g1),
        .adr(c1_adr), .writedata(c1_wd), .memwrite(c1_mw), .memdata(memdata)
    );

    // Memory model standing in for the systembus slave.
    always @(posedge clk) begin
        if (g0 && c0_mw) mem[c0_adr] <= c0_wd;
        else if (g1 && c1_mw) mem[c1_adr] <= c1_wd;
    end

    always_comb begin
        model_rd = 8'd0;
        if (g0) model_rd = mem[c0_adr];
        else if (g1) model_rd = mem[c1_adr];
        else model_rd = 8'd0;
    end

    assign memdata = use_model ? model_rd : md_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: pop the oldest expectation per core on each cpu_done.
    always @(negedge clk) begin
        exp_t e;
        if (c0_done) begin
            if (q0.size() == 0) check("c0_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("c0_done_cycle", cyc, e.cyc);
                check("c0_readdata", {24'd0, c0_rdata}, {24'd0, e.rd});
            end
        end
        if (c1_done) begin
            if (q1.size() == 0) check("c1_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("c1_done_cycle", cyc, e.cyc);
                check("c1_readdata", {24'd0, c1_rdata}, {24'd0, e.rd});
            end
        end
    end

    initial begin
        reset = 1'b1;
        c0_rd = 1'b0; c0_wr = 1'b0; c0_cadr = 8'd0; c0_cwd = 8'd0;
        c1_rd = 1'b0; c1_wr = 1'b0; c1_cadr = 8'd0; c1_cwd = 8'd0;
        g0 = 1'b0; g1 = 1'b0; md_force = 8'd0; use_model = 1'b0;
        exp_rd0 = 8'd0; exp_rd1 = 8'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state.
        check("rst_c0_req", c0_req, 1'b0);
        check("rst_c0_mw", c0_mw, 1'b0);
        check("rst_c0_done", c0_done, 1'b0);
        check("rst_c0_rdata", c0_rdata, 8'd0);
        check("rst_c0_adr", c0_adr, 8'd0);
        check("rst_c0_wd", c0_wd, 8'd0);
        check("rst_c0_stall", c0_stall, 1'b0);
        check("rst_c1_req", c1_req, 1'b0);
        check("rst_c1_rdata", c1_rdata, 8'd0);

        // Write with immediate grant.
        n = cyc;
        c0_wr = 1'b1; c0_cadr = 8'd5; c0_cwd = 8'd207; g0 = 1'b1;
        #1;
        check("wr_issue_stall", c0_stall, 1'b1);
        check("wr_issue_req", c0_req, 1'b0);
        q0.push_back('{n + 2, exp_rd0});
        tick();
        check("wr_req", c0_req, 1'b1);
        check("wr_memwrite", c0_mw, 1'b1);
        check("wr_adr", c0_adr, 8'd5);
        check("wr_wdata", c0_wd, 8'd207);
        tick();
        check("wr_mw_one_cycle", c0_mw, 1'b0);
        check("wr_req_drop", c0_req, 1'b0);
        check("wr_done_stall", c0_stall, 1'b0);
        c0_wr = 1'b0; g0 = 1'b0;
        tick();
        check("wr_done_pulse", c0_done, 1'b0);

        // Read, latency 1.
        check("rd_idle_stall", c0_stall, 1'b0);
        n = cyc;
        c0_rd = 1'b1; c0_cadr = 8'd8; g0 = 1'b1; md_force = 8'd55;
        #1;
        check("rd_issue_stall", c0_stall, 1'b1);
        exp_rd0 = 8'd55;
        q0.push_back('{n + 3, exp_rd0});
        tick();
        check("rd_req", c0_req, 1'b1);
        check("rd_no_mw", c0_mw, 1'b0);
        tick();
        check("rd_wait_stall", c0_stall, 1'b1);
        tick();
        check("rd_done_stall", c0_stall, 1'b0);
        c0_rd = 1'b0; g0 = 1'b0;
        tick();
        check("rd_after_stall", c0_stall, 1'b0);

        // Write with grant delayed by 4 cycles.
        n = cyc;
        c0_wr = 1'b1; c0_cadr = 8'd3; c0_cwd = 8'h11; g0 = 1'b0;
        q0.push_back('{n + 6, exp_rd0});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dly_req", c0_req, 1'b1);
            check("dly_stall", c0_stall, 1'b1);
            check("dly_no_mw", c0_mw, 1'b0);
        end
        tick();
        g0 = 1'b1;
        #1;
        check("dly_mw", c0_mw, 1'b1);
        check("dly_adr", c0_adr, 8'd3);
        check("dly_wdata", c0_wd, 8'h11);
        tick();
        check("dly_mw_drop", c0_mw, 1'b0);
        c0_wr = 1'b0; g0 = 1'b0;
        tick();

        // Preemption during WAIT on the latency-3 master.
        n = cyc;
        c1_rd = 1'b1; c1_cadr = 8'd9; g1 = 1'b1; md_force = 8'hEE;
        exp_rd1 = 8'h3C;
        q1.push_back('{n + 9, exp_rd1});
        tick();
        tick();
        tick();
        g1 = 1'b0;
        #1;
        check("pre_req_hold", c1_req, 1'b1);
        tick();
        check("pre_req_in_req", c1_req, 1'b1);
        check("pre_stall", c1_stall, 1'b1);
        tick();
        g1 = 1'b1;
        tick();
        tick();
        tick();
        md_force = 8'h3C;
        tick();
        md_force = 8'hEE;
        c1_rd = 1'b0; g1 = 1'b0;
        tick();

        // Reset in the middle of a read abandons it.
        c0_rd = 1'b1; c0_cadr = 8'd8; g0 = 1'b1; md_force = 8'h77;
        tick();
        tick();
        reset = 1'b1; c0_rd = 1'b0; g0 = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_mid_req", c0_req, 1'b0);
        check("rst_mid_stall", c0_stall, 1'b0);
        check("rst_mid_rdata", c0_rdata, 8'd0);
        check("rst_mid_done", c0_done, 1'b0);
        check("rst_mid_c1_rdata", c1_rdata, 8'd0);
        exp_rd0 = 8'd0; exp_rd1 = 8'd0;
        n = cyc;
        c0_rd = 1'b1; c0_cadr = 8'd8; g0 = 1'b1; md_force = 8'd9;
        exp_rd0 = 8'd9;
        q0.push_back('{n + 3, exp_rd0});
        repeat (3) tick();
        c0_rd = 1'b0; g0 = 1'b0;
        tick();

        // Two cores store to address 5; core 1 granted first, then core 0.
        use_model = 1'b1;
        n = cyc;
        c0_wr = 1'b1; c0_cadr = 8'd5; c0_cwd = 8'hA0;
        c1_wr = 1'b1; c1_cadr = 8'd5; c1_cwd = 8'hB1;
        q1.push_back('{n + 2, exp_rd1});
        q0.push_back('{n + 3, exp_rd0});
        tick();
        g1 = 1'b1;
        #1;
        check("arb_c1_mw", c1_mw, 1'b1);
        check("arb_c0_no_mw", c0_mw, 1'b0);
        check("arb_c0_req", c0_req, 1'b1);
        tick();
        c1_wr = 1'b0; g1 = 1'b0; g0 = 1'b1;
        #1;
        check("arb_c0_mw", c0_mw, 1'b1);
        check("arb_c1_no_mw", c1_mw, 1'b0);
        tick();
        c0_wr = 1'b0; g0 = 1'b0;
        tick();
        n = cyc;
        c1_rd = 1'b1; c1_cadr = 8'd5; g1 = 1'b1;
        exp_rd1 = 8'hA0;
        q1.push_back('{n + 5, exp_rd1});
        repeat (5) tick();
        c1_rd = 1'b0; g1 = 1'b0;
        repeat (2) tick();

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
